pcie_msi_arbiter: RTL and testbench

Shares the single PCIe core interrupt handshake (`intx_msi_request` / `intx_msi_grant` / `msi_vector_num`) among up to 32 user interrupt sources. It sits in the `user_clk` domain between user logic and the bridge's interrupt ports. It latches rising edges of each source as pending and picks one eligible source round-robin. It maps the source to an MSI vector the host has allocated, runs the request/grant handshake, and enforces a minimum gap between messages.

---
 rtl/pcie_msi_arbiter.sv | 159 +++++++++++++++
 tb/tb_pcie_msi_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_msi_arbiter.sv
// pcie_msi_arbiter
//
// Shares the PCIe core's single interrupt handshake among NUM_IRQ user
// interrupt sources. Each rising edge on irq_in latches a pending flag. One
// eligible source (pending, unmasked, MSI enabled) is picked round-robin and
// mapped to an allocated MSI vector. The request/grant handshake with the core
// then runs, and a holdoff gap is enforced after every grant.
//
// Ports:
//   clk               PCIe user clock, all logic on the rising edge
//   rst               synchronous active-high reset
//   irq_in            per-source interrupt lines (rising edge = one message)
//   irq_mask          1 = source not eligible (pending still latched)
//   msi_enable        0 = no new request is started
//   msi_vector_width  core MMEnable; 2^w vectors allocated, 6/7 treated as 5
//   intx_msi_request  request to core (cfg_interrupt)
//   msi_vector_num    vector number to core (cfg_pciecap_interrupt_msgnum)
//   intx_msi_grant    grant from core (cfg_interrupt_rdy)
//   pending           latched pending flags
//   busy              1 while a message is in flight or in holdoff
//
// Handshake: intx_msi_request acts as "valid" and intx_msi_grant as "ready".
// Once the request is raised, it and msi_vector_num stay stable until a
// clock edge samples the grant high. That edge completes the transfer and
// drops the request. A request is never withdrawn before its grant, except
// by reset.

module pcie_msi_arbiter #(
  parameter int NUM_IRQ        = 8,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               msi_enable,
  input  logic [2:0]         msi_vector_width,
  output logic               intx_msi_request,
  output logic [4:0]         msi_vector_num,
  input  logic               intx_msi_grant,
  output logic [NUM_IRQ-1:0] pending,
  output logic               busy
);

  localparam int PTR_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] irq_q;
  logic [PTR_W-1:0]   rr_ptr;
  logic [15:0]        hold_cnt;
  logic [4:0]         sel;

  logic [NUM_IRQ-1:0] irq_edge;
  logic [NUM_IRQ-1:0] eligible;
  logic               any_eligible;
  logic [NUM_IRQ-1:0] rot;
  logic [5:0]         off;
  logic [5:0]         sum;
  logic [4:0]         win;
  logic [2:0]         w_cl;
  logic [4:0]         vec_max;
  logic [4:0]         win_vec;
  logic [PTR_W-1:0]   rr_after_sel;
  logic               grant_evt;
  logic [NUM_IRQ-1:0] grant_clr;

  assign irq_edge     = irq_in & ~irq_q;
  assign eligible     = msi_enable ? (pending & ~irq_mask) : '0;
  assign any_eligible = |eligible;

  // Round-robin search. Rotate the eligible set so bit 0 corresponds to
  // rr_ptr, take the lowest set bit, then rotate the offset back into a
  // source index.
  always_comb begin
    rot = NUM_IRQ'({eligible, eligible} >> rr_ptr);
    off = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (rot[k]) off = 6'(k);
    end
    sum = 6'(rr_ptr) + off;
    if (sum >= 6'(NUM_IRQ)) sum = sum - 6'(NUM_IRQ);
    win = sum[4:0];
  end

  // Sources above the highest allocated vector share that top vector.
  always_comb begin
    w_cl    = (msi_vector_width > 3'd5) ? 3'd5 : msi_vector_width;
    vec_max = 5'((6'd1 << w_cl) - 6'd1);
    win_vec = (win > vec_max) ? vec_max : win;
  end

  assign rr_after_sel = (sel == 5'(NUM_IRQ - 1)) ? '0 : PTR_W'(sel + 5'd1);

  // A new edge on the granted source in the grant cycle re-sets the flag.
  // The set term is OR-ed in after the clear, so the set wins.
  assign grant_evt = (state == S_REQ) && intx_msi_grant;
  assign grant_clr = grant_evt ? (NUM_IRQ'(1'b1) << sel) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      irq_q            <= '0;
      pending          <= '0;
      rr_ptr           <= '0;
      hold_cnt         <= '0;
      sel              <= '0;
      intx_msi_request <= 1'b0;
      msi_vector_num   <= '0;
      busy             <= 1'b0;
    end else begin
      irq_q   <= irq_in;
      pending <= (pending & ~grant_clr) | irq_edge;
      case (state)
        S_IDLE: begin
          if (any_eligible) begin
            sel              <= win;
            msi_vector_num   <= win_vec;
            intx_msi_request <= 1'b1;
            busy             <= 1'b1;
            state            <= S_REQ;
          end
        end
        S_REQ: begin
          if (intx_msi_grant) begin
            intx_msi_request <= 1'b0;
            rr_ptr           <= rr_after_sel;
            if (HOLDOFF_CYCLES == 0) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              hold_cnt <= 16'(HOLDOFF_CYCLES - 1);
              state    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (hold_cnt == 16'd0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt - 16'd1;
          end
        end
        default: begin
          intx_msi_request <= 1'b0;
          busy             <= 1'b0;
          state            <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_msi_arbiter.sv
// Testbench for pcie_msi_arbiter (NUM_IRQ=8, HOLDOFF_CYCLES=4).
// A behavioural model tracks pending flags, the round-robin pointer and the
// busy window. Every message it starts pushes its vector into exp_q. A
// monitor pops exp_q on each rising request from the DUT. Request, busy,
// pending and the held vector are also compared every cycle.

module tb_pcie_msi_arbiter;

  localparam int N = 8;
  localparam int H = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq_in;
  logic [N-1:0] irq_mask;
  logic         msi_enable;
  logic [2:0]   msi_vector_width;
  logic         intx_msi_request;
  logic [4:0]   msi_vector_num;
  logic         intx_msi_grant;
  logic [N-1:0] pending;
  logic         busy;

  pcie_msi_arbiter #(.NUM_IRQ(N), .HOLDOFF_CYCLES(H)) dut (
    .clk              (clk),
    .rst              (rst),
    .irq_in           (irq_in),
    .irq_mask         (irq_mask),
    .msi_enable       (msi_enable),
    .msi_vector_width (msi_vector_width),
    .intx_msi_request (intx_msi_request),
    .msi_vector_num   (msi_vector_num),
    .intx_msi_grant   (intx_msi_grant),
    .pending          (pending),
    .busy             (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  int gnt_max = 0;
  int gnt_wait = 0;
  logic [4:0] exp_q[$];

  // ---------------- reference model ----------------
  bit [N-1:0] m_pend, m_prev;
  int         m_rr, m_sel, m_vec, m_hold;
  bit         m_req;

  always @(posedge clk) begin
    bit [N-1:0] edge_v, clr;
    int wcl, lim, idx;
    bit found;
    edge_v = irq_in & ~m_prev;
    clr    = '0;
    if (rst) begin
      m_pend = '0; m_prev = '0; m_rr = 0; m_sel = 0;
      m_vec = 0; m_hold = 0; m_req = 1'b0;
    end else begin
      if (m_req) begin
        if (intx_msi_grant) begin
          m_req      = 1'b0;
          clr[m_sel] = 1'b1;
          m_rr       = (m_sel + 1) % N;
          m_hold     = H;
        end
      end else if (m_hold > 0) begin
        m_hold = m_hold - 1;
      end else if (msi_enable) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (!found && m_pend[idx] && !irq_mask[idx]) begin
            found = 1'b1;
            m_sel = idx;
          end
        end
        if (found) begin
          wcl   = (msi_vector_width > 5) ? 5 : int'(msi_vector_width);
          lim   = (1 << wcl) - 1;
          m_vec = (m_sel < lim) ? m_sel : lim;
          m_req = 1'b1;
          exp_q.push_back(5'(m_vec));
        end
      end
      m_pend = (m_pend & ~clr) | edge_v;
      m_prev = irq_in;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  logic req_prev = 1'b0;

  always @(negedge clk) begin
    logic [4:0] e;
    check("request", 32'(intx_msi_request), 32'(m_req));
    check("busy", 32'(busy), 32'(m_req || (m_hold > 0)));
    check("pending", 32'(pending), 32'(m_pend));
    if (m_req) check("vector_held", 32'(msi_vector_num), 32'(m_vec));
    if (intx_msi_request && !req_prev) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_vector: got request vector %0d expected no request at t=%0t",
                 msi_vector_num, $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_vector", 32'(msi_vector_num), 32'(e));
      end
    end
    req_prev = intx_msi_request;
  end

  // ---------------- core grant emulation ----------------
  initial begin
    intx_msi_grant = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || intx_msi_grant) begin
        intx_msi_grant = 1'b0;
      end else if (intx_msi_request) begin
        if (gnt_wait == 0) intx_msi_grant = 1'b1;
        else gnt_wait--;
      end else begin
        gnt_wait = $urandom_range(0, gnt_max);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    tick();
    irq_in = irq_in | m;
    tick();
    irq_in = irq_in & ~m;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((m_req || m_hold > 0 || m_pend != '0) && n < limit) begin
      tick();
      n++;
    end
    tests++;
    if (m_req || m_hold > 0 || m_pend != '0) begin
      fails++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", limit);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bit seen;
    rst = 1'b1; irq_in = '0; irq_mask = '0; msi_enable = 1'b1;
    msi_vector_width = 3'd3;
    repeat (3) tick();
    rst = 1'b0;

    // single source
    gnt_max = 3;
    pulse(8'h20);
    wait_idle(200);

    // round-robin with immediate grants, twice
    gnt_max = 0;
    pulse(8'b0100_1010);
    wait_idle(200);
    pulse(8'b0100_1010);
    wait_idle(200);

    // vector clamp
    msi_vector_width = 3'd1;
    pulse(8'h40);
    wait_idle(200);
    msi_vector_width = 3'd7;
    pulse(8'h40);
    wait_idle(200);
    msi_vector_width = 3'd3;

    // mask and enable
    msi_enable = 1'b0;
    pulse(8'h04);
    repeat (10) tick();
    irq_mask = 8'h04;
    msi_enable = 1'b1;
    repeat (10) tick();
    irq_mask = '0;
    wait_idle(200);

    // edge on the selected source in the grant cycle
    gnt_max = 2;
    pulse(8'h20);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 50) begin
      @(posedge clk);
      #2;
      if (intx_msi_grant) seen = 1'b1;
      n++;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL grant_wait: no grant within 50 cycles, required one");
    end else begin
      irq_in[5] = 1'b1;
      tick();
      irq_in[5] = 1'b0;
    end
    wait_idle(200);

    // reset in REQ; line 0 held high across reset release
    pulse(8'hff);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 50) begin
      @(posedge clk);
      #2;
      if (intx_msi_request) seen = 1'b1;
      n++;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL req_wait: no request within 50 cycles, required one");
    end
    rst = 1'b1;
    irq_in = 8'h01;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    irq_in = '0;
    wait_idle(200);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      tick();
      irq_in = irq_in ^ N'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 31) == 0) irq_mask = N'($urandom & $urandom);
      if ($urandom_range(0, 63) == 0) msi_enable = ~msi_enable;
      if ($urandom_range(0, 63) == 0) msi_vector_width = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) gnt_max = $urandom_range(0, 4);
    end
    irq_in = '0;
    irq_mask = '0;
    msi_enable = 1'b1;
    wait_idle(2000);
    repeat (2) tick();

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: %0d expected messages never issued, required 0", exp_q.size());
    end

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
